adc_freq_meter: RTL and testbench

//  Capture-side counterpart of the DDS/DAC output path: receives 8-bit ADC samples of the looped-back

---
 rtl/adc_freq_meter.sv | 181 ++++++++++++++++++
 tb/tb_adc_freq_meter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_freq_meter.sv
// ============================================================================
// adc_freq_meter : Schmitt-squared ADC edge counter over a fixed gate window,
//                  reported as 5-digit BCD Hz. Optional ADC_FREQ_AVG_EN macro
//                  averages the current and previous window.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int MID_LEVEL   = 128,
  parameter int HYST        = 8,
  parameter int MAX_COUNT   = 99999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  output logic [19:0] number_on_digitron,
  output logic [5:0]  point_position,
  output logic        freq_valid,
  output logic        overrange
);

  localparam int                  c_gate_w   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
  localparam int                  c_thr_hi_i = (MID_LEVEL + HYST > 255) ? 255 : MID_LEVEL + HYST;
  localparam int                  c_thr_lo_i = (MID_LEVEL - HYST < 0) ? 0 : MID_LEVEL - HYST;
  localparam logic [7:0]          c_thr_hi   = 8'(c_thr_hi_i);
  localparam logic [7:0]          c_thr_lo   = 8'(c_thr_lo_i);
  localparam logic [16:0]         c_max      = 17'(MAX_COUNT);
  localparam logic [4:0]          c_iters    = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic                r_cmp_high;
  logic                w_rise;
  logic                w_fall;
  logic                w_gate_term;
  logic [c_gate_w-1:0] r_gate_cnt;
  logic [16:0]         r_edge_cnt;
  logic                r_sat;
  logic [16:0]         r_result;
  logic                r_result_sat;
  logic                r_start;
  logic [16:0]         w_bcd_in;
  logic                w_bcd_sat;

  state_t              r_state;
  logic [36:0]         r_dd;
  logic [36:0]         w_dd_adj;
  logic [36:0]         w_dd_next;
  logic [4:0]          r_iter;
  logic                r_dd_sat;

  assign w_rise      = adc_valid && !r_cmp_high && (adc_data >= c_thr_hi);
  assign w_fall      = adc_valid &&  r_cmp_high && (adc_data <= c_thr_lo);
  assign w_gate_term = (r_gate_cnt == c_gate_last);
  assign point_position = 6'b000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_high <= 1'b0;
    end else if (w_rise) begin
      r_cmp_high <= 1'b1;
    end else if (w_fall) begin
      r_cmp_high <= 1'b0;
    end
  end

  // A rise on the terminal cycle belongs to the window that starts next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_result     <= '0;
      r_result_sat <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_start <= w_gate_term;
      if (w_gate_term) begin
        r_gate_cnt   <= '0;
        r_result     <= r_edge_cnt;
        r_result_sat <= r_sat;
        r_edge_cnt   <= w_rise ? 17'd1 : 17'd0;
        r_sat        <= 1'b0;
      end else begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
        if (w_rise) begin
          if (r_edge_cnt >= c_max - 17'd1) begin
            r_edge_cnt <= c_max;
            r_sat      <= 1'b1;
          end else begin
            r_edge_cnt <= r_edge_cnt + 17'd1;
          end
        end
      end
    end
  end

`ifdef ADC_FREQ_AVG_EN
  logic [16:0] r_prev_result;
  logic        r_prev_sat;
  logic        r_have_result;
  logic        r_have_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_result <= '0;
      r_prev_sat    <= 1'b0;
      r_have_result <= 1'b0;
      r_have_prev   <= 1'b0;
    end else if (w_gate_term) begin
      r_prev_result <= r_result;
      r_prev_sat    <= r_result_sat;
      r_have_prev   <= r_have_result;
      r_have_result <= 1'b1;
    end
  end

  assign w_bcd_in  = r_have_prev ? 17'(({1'b0, r_result} + {1'b0, r_prev_result}) >> 1) : r_result;
  assign w_bcd_sat = r_result_sat | (r_have_prev & r_prev_sat);
`else
  assign w_bcd_in  = r_result;
  assign w_bcd_sat = r_result_sat;
`endif

  // Double-dabble: r_dd = {bcd[19:0], bin[16:0]}; add-3 on digits >= 5, then shift.
  for (genvar i = 0; i < 5; i++) begin : g_digit
    assign w_dd_adj[17+4*i +: 4] = (r_dd[17+4*i +: 4] >= 4'd5) ? r_dd[17+4*i +: 4] + 4'd3
                                                                : r_dd[17+4*i +: 4];
  end
  assign w_dd_adj[16:0] = r_dd[16:0];
  assign w_dd_next      = w_dd_adj << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= ST_IDLE;
      r_dd               <= '0;
      r_iter             <= '0;
      r_dd_sat           <= 1'b0;
      number_on_digitron <= '0;
      overrange          <= 1'b0;
      freq_valid         <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_start) begin
            r_dd     <= {20'd0, w_bcd_in};
            r_dd_sat <= w_bcd_sat;
            r_iter   <= '0;
            r_state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_dd   <= w_dd_next;
          r_iter <= r_iter + 5'd1;
          if (r_iter == c_iters - 5'd1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          number_on_digitron <= r_dd[36:17];
          overrange          <= r_dd_sat;
          freq_valid         <= 1'b1;
          r_state            <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_freq_meter.sv
// ============================================================================
// tb_adc_freq_meter : scoreboard bench for adc_freq_meter (GATE_CYCLES=1000).
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_freq_meter;

  localparam int GATE = 1000;
  localparam int MAXC = 400;

  localparam int M_SQ100     = 0;
  localparam int M_HYS       = 1;
  localparam int M_SQ100_ODD = 2;
  localparam int M_SQ2_ODD   = 3;
  localparam int M_SQ2       = 4;
  localparam int M_SQ50      = 5;
  localparam int M_THR100    = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adc_data = 8'd0;
  logic        adc_valid = 1'b0;
  logic [19:0] number_on_digitron;
  logic [5:0]  point_position;
  logic        freq_valid;
  logic        overrange;

  always #5 clk = ~clk;

  adc_freq_meter #(
    .GATE_CYCLES(GATE),
    .MID_LEVEL  (128),
    .HYST       (8),
    .MAX_COUNT  (MAXC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .number_on_digitron(number_on_digitron),
    .point_position    (point_position),
    .freq_valid        (freq_valid),
    .overrange         (overrange)
  );

  typedef struct {
    logic [19:0] digits;
    logic        ovr;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  int   ep_mode[8];
  int   ep_raw[8];
  int   m_prev;
  logic m_prev_sat;
  logic m_have_prev;

  // Edge index since reset release; a report registered at edge n reads cyc==n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic push_window(input int w, input int raw);
    int   cnt;
    logic sat;
    int   rep;
    logic rsat;
    exp_t e;
    cnt = (raw >= MAXC) ? MAXC : raw;
    sat = (raw >= MAXC);
`ifdef ADC_FREQ_AVG_EN
    if (m_have_prev) begin
      rep  = (cnt + m_prev) / 2;
      rsat = sat | m_prev_sat;
    end else begin
      rep  = cnt;
      rsat = sat;
    end
    m_prev      = cnt;
    m_prev_sat  = sat;
    m_have_prev = 1'b1;
`else
    rep  = cnt;
    rsat = sat;
`endif
    e.digits = to_bcd(rep);
    e.ovr    = rsat;
    e.cyc    = (w + 1) * GATE + 19;
    sb_q.push_back(e);
  endtask

  function automatic void gen(input int mode, input int n, output logic [7:0] d, output logic v);
    logic lvl;
    v = 1'b1;
    d = 8'd0;
    case (mode)
      M_SQ100: d = (n % 100 >= 50) ? 8'd255 : 8'd0;
      M_HYS: begin
        case (n % 4)
          0:       d = 8'd130;
          1:       d = 8'd126;
          2:       d = 8'd131;
          default: d = 8'd125;
        endcase
      end
      M_SQ100_ODD: begin
        // Invalid cycles carry the opposite level so an unqualified sampler would count.
        v   = (n % 2 == 1);
        lvl = (n % 100 >= 50) ^ !v;
        d   = lvl ? 8'd255 : 8'd0;
      end
      M_SQ2_ODD: begin
        v = (n % 2 == 1);
        d = v ? 8'd255 : 8'd0;
      end
      M_SQ2:    d = (n % 2 == 1) ? 8'd255 : 8'd0;
      M_SQ50:   d = (n % 50 >= 25) ? 8'd255 : 8'd0;
      M_THR100: d = (n % 100 >= 50) ? 8'd136 : 8'd120;
      default:  d = 8'd0;
    endcase
  endfunction

  task automatic run_epoch(input int nrep, input int ncyc);
    logic [7:0] d;
    logic       v;
    m_have_prev = 1'b0;
    m_prev      = 0;
    m_prev_sat  = 1'b0;
    for (int w = 0; w < nrep; w++) push_window(w, ep_raw[w]);
    for (int n = 1; n <= ncyc; n++) begin
      gen(ep_mode[n / GATE], n, d, v);
      adc_data  = d;
      adc_valid = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_digits"}, 32'(number_on_digitron), 32'h0);
    check({tag, "_point"},  32'(point_position),     32'h0);
    check({tag, "_valid"},  32'(freq_valid),         32'h0);
    check({tag, "_ovr"},    32'(overrange),          32'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && freq_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_freq_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("digits",  32'(number_on_digitron), 32'(e.digits));
        check("ovr",     32'(overrange),          32'(e.ovr));
        check("latency", 32'(cyc),                32'(e.cyc));
        check("point",   32'(point_position),     32'h0);
      end
    end
  end

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Hand-computed rising-crossing counts per window.
    ep_mode = '{M_SQ100, M_SQ100, M_HYS, M_SQ100_ODD, M_SQ2_ODD, M_SQ2, M_SQ100, M_SQ100};
    ep_raw  = '{10, 10, 0, 10, 0, 500, 10, 0};
    run_epoch(7, 7500);

    check("queue_drained_before_reset", 32'(sb_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    ep_mode = '{M_SQ100, M_SQ50, M_THR100, M_THR100, M_SQ100, M_SQ100, M_SQ100, M_SQ100};
    ep_raw  = '{10, 20, 10, 0, 0, 0, 0, 0};
    run_epoch(3, 3030);

    check("queue_drained_at_end", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
